// File: rtl/iir_biquad_sequencer.sv
// rtl/iir_biquad_sequencer.sv - direct-form-I biquad sequencer sharing one signed MAC across five taps
// Accepts x[n], runs b0,b1,b2,-a1,-a2 products over five cycles, then rescales and saturates y[n].
module iir_biquad_sequencer #(
   parameter int DW = 16,
   parameter int CW = 18,
   parameter int CF = 16,
   parameter int GW = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] out_data,
   output logic                 out_sat,
   input  logic                 cfg_we,
   input  logic [2:0]           cfg_addr,
   input  logic signed [CW-1:0] cfg_data,
   input  logic                 hist_clr
);
   localparam int AW = DW + CW + GW;
   localparam int PW = DW + CW;
   localparam logic signed [DW-1:0] D_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] D_MIN = {1'b1, {(DW-1){1'b0}}};
   localparam logic signed [AW-1:0] R_MAX = AW'(D_MAX);
   localparam logic signed [AW-1:0] R_MIN = AW'(D_MIN);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   state_t               state_q, state_d;
   logic [2:0]           tap_q, tap_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic signed [DW-1:0] x_q, x_d, x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
   logic signed [CW-1:0] coef_q [0:4];
   logic signed [CW-1:0] coef_d [0:4];
   logic                 out_valid_q, out_valid_d, out_sat_q, out_sat_d;
   logic signed [DW-1:0] out_data_q, out_data_d;

   logic signed [CW-1:0] mul_c;
   logic signed [DW-1:0] mul_d;
   logic                 mul_neg;
   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] prod_ext, term, sum, r;
   logic signed [DW-1:0] sat_val;
   logic                 sat_hit;

   // Feedback taps subtract: negate the full-width product, never the stored coefficient.
   always_comb begin
      mul_c   = '0;
      mul_d   = '0;
      mul_neg = 1'b0;
      case (tap_q)
         3'd0: begin mul_c = coef_q[0]; mul_d = x_q;  end
         3'd1: begin mul_c = coef_q[1]; mul_d = x1_q; end
         3'd2: begin mul_c = coef_q[2]; mul_d = x2_q; end
         3'd3: begin mul_c = coef_q[3]; mul_d = y1_q; mul_neg = 1'b1; end
         3'd4: begin mul_c = coef_q[4]; mul_d = y2_q; mul_neg = 1'b1; end
         default: ;
      endcase
      prod     = PW'(mul_c) * PW'(mul_d);
      prod_ext = {{GW{prod[PW-1]}}, prod};
      term     = mul_neg ? -prod_ext : prod_ext;
      sum      = acc_q + term;
      r        = sum >>> CF;
      sat_hit  = 1'b1;
      if (r > R_MAX)      sat_val = D_MAX;
      else if (r < R_MIN) sat_val = D_MIN;
      else begin
         sat_val = r[DW-1:0];
         sat_hit = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      tap_d       = tap_q;
      acc_d       = acc_q;
      x_d         = x_q;
      x1_d        = x1_q;
      x2_d        = x2_q;
      y1_d        = y1_q;
      y2_d        = y2_q;
      coef_d      = coef_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      case (state_q)
         S_IDLE: begin
            if (cfg_we && cfg_addr <= 3'd4) coef_d[cfg_addr] = cfg_data;
            if (hist_clr) begin
               x1_d = '0;
               x2_d = '0;
               y1_d = '0;
               y2_d = '0;
            end
            if (in_valid) begin
               x_d     = in_data;
               acc_d   = '0;
               tap_d   = '0;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = sum;
            if (tap_q == 3'd4) begin
               out_data_d  = sat_val;
               out_sat_d   = sat_hit;
               out_valid_d = 1'b1;
               x2_d        = x1_q;
               x1_d        = x_q;
               y2_d        = y1_q;
               y1_d        = sat_val;
               tap_d       = '0;
               state_d     = S_OUT;
            end else begin
               tap_d = tap_q + 3'd1;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         tap_q       <= '0;
         acc_q       <= '0;
         x_q         <= '0;
         x1_q        <= '0;
         x2_q        <= '0;
         y1_q        <= '0;
         y2_q        <= '0;
         for (int i = 0; i < 5; i++) coef_q[i] <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         acc_q       <= acc_d;
         x_q         <= x_d;
         x1_q        <= x1_d;
         x2_q        <= x2_d;
         y1_q        <= y1_d;
         y2_q        <= y2_d;
         coef_q      <= coef_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// tb/tb_iir_biquad_sequencer.sv - directed self-checking bench for iir_biquad_sequencer
module tb_iir_biquad_sequencer;
   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] in_data = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [15:0] out_data;
   logic               out_sat;
   logic               cfg_we = 1'b0;
   logic [2:0]         cfg_addr = '0;
   logic signed [17:0] cfg_data = '0;
   logic               hist_clr = 1'b0;

   int checks = 0;
   int errors = 0;

   iir_biquad_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .hist_clr(hist_clr)
   );

   always #5 clk = ~clk;

   task automatic wr(input logic [2:0] a, input logic signed [17:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      @(posedge clk);
      #1 cfg_we = 1'b0;
   endtask

   task automatic clr_hist();
      @(negedge clk);
      hist_clr = 1'b1;
      @(posedge clk);
      #1 hist_clr = 1'b0;
   endtask

   // Accept one sample (optionally with hist_clr on the accept edge, or a b0 write during MAC) and check its output.
   task automatic send(input logic signed [15:0] d, input logic signed [15:0] exp_d, input logic exp_s,
                       input logic with_clr, input logic mid_cfg, input string name);
      int n;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL %s in_ready before accept got %b want 1", name, in_ready);
      end
      in_valid = 1'b1; in_data = d; hist_clr = with_clr;
      @(posedge clk);
      #1 in_valid = 1'b0; in_data = 16'sd0; hist_clr = 1'b0;
      if (mid_cfg) begin
         cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 18'sd32768;
      end
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1 cfg_we = 1'b0;
         @(negedge clk);
      end while (!out_valid && n < 20);
      checks++;
      if (n !== 5) begin
         errors++; $display("FAIL %s latency got %0d want 5", name, n);
      end
      checks++;
      if (out_data !== exp_d || out_sat !== exp_s) begin
         errors++; $display("FAIL %s out got %0d sat %b want %0d sat %b", name, out_data, out_sat, exp_d, exp_s);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL %s after handshake valid %b ready %b want 0 1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'sd0 || out_sat !== 1'b0) begin
         errors++; $display("FAIL reset ready %b valid %b data %0d sat %b want 1 0 0 0", in_ready, out_valid, out_data, out_sat);
      end
   endtask

   task automatic test_passthrough();
      wr(3'd0, 18'sd65536);
      send(16'sd1000, 16'sd1000, 1'b0, 1'b0, 1'b0, "pass_1000");
      send(-16'sd1234, -16'sd1234, 1'b0, 1'b0, 1'b0, "pass_m1234");
   endtask

   task automatic test_recursion();
      wr(3'd3, -18'sd32768);
      clr_hist();
      send(16'sd1000, 16'sd1000, 1'b0, 1'b0, 1'b0, "rec_0");
      send(16'sd0, 16'sd500, 1'b0, 1'b0, 1'b0, "rec_1");
      send(16'sd0, 16'sd250, 1'b0, 1'b0, 1'b0, "rec_2");
      send(16'sd0, 16'sd125, 1'b0, 1'b0, 1'b0, "rec_3");
      clr_hist();
      send(16'sd0, 16'sd0, 1'b0, 1'b0, 1'b0, "rec_clr");
      send(16'sd1000, 16'sd1000, 1'b0, 1'b0, 1'b0, "rec_pre");
      send(16'sd0, 16'sd0, 1'b0, 1'b1, 1'b0, "rec_clr_same_edge");
      wr(3'd3, 18'sd0);
   endtask

   task automatic test_all_taps();
      clr_hist();
      wr(3'd1, 18'sd32768);
      wr(3'd2, 18'sd16384);
      wr(3'd4, -18'sd16384);
      send(16'sd800, 16'sd800, 1'b0, 1'b0, 1'b0, "taps_0");
      send(16'sd0, 16'sd400, 1'b0, 1'b0, 1'b0, "taps_1");
      send(16'sd0, 16'sd400, 1'b0, 1'b0, 1'b0, "taps_2");
      wr(3'd1, 18'sd0);
      wr(3'd2, 18'sd0);
      wr(3'd4, 18'sd0);
   endtask

   task automatic test_saturation();
      wr(3'd0, 18'sd98304);
      send(16'sd30000, 16'sd32767, 1'b1, 1'b0, 1'b0, "sat_pos");
      send(-16'sd30000, -16'sd32768, 1'b1, 1'b0, 1'b0, "sat_neg");
      wr(3'd0, 18'sd32768);
      send(-16'sd3, -16'sd2, 1'b0, 1'b0, 1'b0, "floor_m3");
      wr(3'd0, 18'sd65536);
      send(16'sd32767, 16'sd32767, 1'b0, 1'b0, 1'b0, "edge_max");
   endtask

   task automatic test_backpressure();
      int n;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'sd700;
      @(posedge clk);
      #1 in_data = 16'sd800;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!out_valid && n < 20);
      checks++;
      if (n !== 5) begin
         errors++; $display("FAIL bp latency got %0d want 5", n);
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 16'sd700 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp hold cyc %0d valid %b data %0d ready %b want 1 700 0", i, out_valid, out_data, in_ready);
         end
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL bp release ready %b valid %b want 1 0", in_ready, out_valid);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL bp second accept ready %b want 0", in_ready);
      end
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!out_valid && n < 20);
      checks++;
      if (n !== 5 || out_data !== 16'sd800) begin
         errors++; $display("FAIL bp second out got %0d after %0d want 800 after 5", out_data, n);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_config_gating();
      send(16'sd100, 16'sd100, 1'b0, 1'b0, 1'b1, "cfg_mid_cur");
      send(16'sd200, 16'sd200, 1'b0, 1'b0, 1'b0, "cfg_mid_next");
      wr(3'd6, 18'sd32768);
      wr(3'd7, 18'sd12345);
      send(16'sd300, 16'sd300, 1'b0, 1'b0, 1'b0, "cfg_addr6");
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'sd1000;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'sd0) begin
         errors++; $display("FAIL midop reset valid %b ready %b data %0d want 0 1 0", out_valid, in_ready, out_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send(16'sd1000, 16'sd0, 1'b0, 1'b0, 1'b0, "midop_after");
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      test_passthrough();
      test_recursion();
      test_all_taps();
      test_saturation();
      test_backpressure();
      test_config_gating();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
